// File: rtl/puzzle_dealer_if.sv
// Request/deal bus between the game-control FSM (master) and the puzzle dealer (slave).
interface puzzle_dealer_if #(
  parameter int IDX_W = 5,
  parameter int NUM_W = 4
) ();
  logic             deal_req;
  logic             shuffle_en;
  logic [NUM_W-1:0] num1;
  logic [NUM_W-1:0] num2;
  logic [NUM_W-1:0] num3;
  logic [NUM_W-1:0] num4;
  logic [IDX_W-1:0] set_idx;
  logic             deal_valid;
  logic             busy;
  logic             deck_wrap;
  logic [IDX_W:0]   dealt_count;

  modport master (
    output deal_req, shuffle_en,
    input  num1, num2, num3, num4, set_idx, deal_valid, busy, deck_wrap, dealt_count
  );

  modport slave (
    input  deal_req, shuffle_en,
    output num1, num2, num3, num4, set_idx, deal_valid, busy, deck_wrap, dealt_count
  );
endinterface

// File: rtl/puzzle_dealer.sv
// Deals one solvable 24-game set per request from a fixed table, never repeating
// within a deck and starting a fresh deck automatically once every set is used.
module puzzle_dealer #(
  parameter int         SET_COUNT = 32,
  parameter int         IDX_W     = 5,
  parameter int         NUM_W     = 4,
  parameter logic [4:0] LFSR_SEED = 5'h15
) (
  input logic            clk,
  input logic            rst,
  puzzle_dealer_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [IDX_W:0]   DECK_FULL = (IDX_W+1)'(SET_COUNT);
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  state_t                 state;
  logic [SET_COUNT-1:0]   used;
  logic [IDX_W-1:0]       seq_ptr;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       lfsr;
  logic [15:0]            entry;

  // Each entry packs the four numbers as nibbles, num1 in the top nibble.
  function automatic logic [15:0] table_entry(input logic [4:0] i);
    case (i)
      5'd0:    table_entry = 16'h248B;
      5'd1:    table_entry = 16'h26CD;
      5'd2:    table_entry = 16'h357D;
      5'd3:    table_entry = 16'h366B;
      5'd4:    table_entry = 16'h137C;
      5'd5:    table_entry = 16'h789A;
      5'd6:    table_entry = 16'h26BC;
      5'd7:    table_entry = 16'h348D;
      5'd8:    table_entry = 16'h36AA;
      5'd9:    table_entry = 16'h449C;
      5'd10:   table_entry = 16'h4679;
      5'd11:   table_entry = 16'h56BD;
      5'd12:   table_entry = 16'h88BC;
      5'd13:   table_entry = 16'hBCCD;
      5'd14:   table_entry = 16'h1346;
      5'd15:   table_entry = 16'h78AD;
      5'd16:   table_entry = 16'h1234;
      5'd17:   table_entry = 16'h1138;
      5'd18:   table_entry = 16'h2223;
      5'd19:   table_entry = 16'h4446;
      5'd20:   table_entry = 16'h1555;
      5'd21:   table_entry = 16'h3388;
      5'd22:   table_entry = 16'h6666;
      5'd23:   table_entry = 16'h234C;
      5'd24:   table_entry = 16'h1668;
      5'd25:   table_entry = 16'h3456;
      5'd26:   table_entry = 16'h1277;
      5'd27:   table_entry = 16'h259A;
      5'd28:   table_entry = 16'h44AA;
      5'd29:   table_entry = 16'h1456;
      5'd30:   table_entry = 16'h235C;
      default: table_entry = 16'h1699;
    endcase
  endfunction

  assign entry    = table_entry(5'(cand));
  assign bus.busy = (state != IDLE);

  // Taps sit at the top bit and bit 2 for both x^5+x^3+1 and x^4+x^3+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      used            <= '0;
      seq_ptr         <= '0;
      cand            <= '0;
      lfsr            <= LFSR_SEED[IDX_W-1:0];
      bus.num1        <= '0;
      bus.num2        <= '0;
      bus.num3        <= '0;
      bus.num4        <= '0;
      bus.set_idx     <= '0;
      bus.deal_valid  <= 1'b0;
      bus.deck_wrap   <= 1'b0;
      bus.dealt_count <= '0;
    end else begin
      lfsr           <= {lfsr[IDX_W-2:0], lfsr[IDX_W-1] ^ lfsr[2]};
      bus.deal_valid <= 1'b0;
      bus.deck_wrap  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.deal_req) begin
            cand  <= bus.shuffle_en ? lfsr : seq_ptr;
            state <= SCAN;
            if (bus.dealt_count == DECK_FULL) begin
              used            <= '0;
              bus.dealt_count <= '0;
              bus.deck_wrap   <= 1'b1;
            end
          end
        end
        SCAN: begin
          // The deck is never full here, so this walk always finds a free slot.
          if (used[cand]) begin
            cand <= cand + IDX_ONE;
          end else begin
            bus.num1        <= NUM_W'(entry[15:12]);
            bus.num2        <= NUM_W'(entry[11:8]);
            bus.num3        <= NUM_W'(entry[7:4]);
            bus.num4        <= NUM_W'(entry[3:0]);
            bus.set_idx     <= cand;
            used[cand]      <= 1'b1;
            seq_ptr         <= cand + IDX_ONE;
            bus.dealt_count <= bus.dealt_count + CNT_ONE;
            bus.deal_valid  <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puzzle_dealer.sv
// Scoreboard bench for puzzle_dealer: a 32-set and a 16-set instance checked
// against a behavioural deck model with its own LFSR copy.
module tb_puzzle_dealer;

  typedef struct packed {
    logic       wrap;
    logic [4:0] idx;
    logic [15:0] nums;
    logic [5:0] cnt;
    logic [5:0] lat;
  } rec_t;

  localparam logic [15:0] TABLE [32] = '{
    16'h248B, 16'h26CD, 16'h357D, 16'h366B, 16'h137C, 16'h789A, 16'h26BC, 16'h348D,
    16'h36AA, 16'h449C, 16'h4679, 16'h56BD, 16'h88BC, 16'hBCCD, 16'h1346, 16'h78AD,
    16'h1234, 16'h1138, 16'h2223, 16'h4446, 16'h1555, 16'h3388, 16'h6666, 16'h234C,
    16'h1668, 16'h3456, 16'h1277, 16'h259A, 16'h44AA, 16'h1456, 16'h235C, 16'h1699
  };

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  puzzle_dealer_if #(.IDX_W(5), .NUM_W(4)) bus_a ();
  puzzle_dealer_if #(.IDX_W(4), .NUM_W(4)) bus_b ();

  puzzle_dealer #(.SET_COUNT(32), .IDX_W(5), .NUM_W(4), .LFSR_SEED(5'h15)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  puzzle_dealer #(.SET_COUNT(16), .IDX_W(4), .NUM_W(4), .LFSR_SEED(5'h15)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  rec_t        exp_q[$];
  logic [31:0] m_used [2];
  int          m_seq  [2];
  int          m_cnt  [2];
  logic [4:0]  m_lfsr [2];
  int          sz     [2] = '{32, 16};

  // Model LFSRs free-run exactly like the hardware ones, from their seeds.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr[0] <= 5'h15;
      m_lfsr[1] <= 5'h05;
    end else begin
      m_lfsr[0] <= {m_lfsr[0][3:0], m_lfsr[0][4] ^ m_lfsr[0][2]};
      m_lfsr[1] <= {1'b0, m_lfsr[1][2:0], m_lfsr[1][3] ^ m_lfsr[1][2]};
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_a.deal_req = 1'b0;
    bus_b.deal_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_used[i] = '0;
      m_seq[i]  = 0;
      m_cnt[i]  = 0;
    end
  endtask

  // Pushes the model's expected deal, issues one request and captures what the DUT deals.
  task automatic deal(input int inst, input logic shuf, output rec_t obs);
    rec_t e;
    int   cand;
    int   k;
    logic v;
    logic w;
    @(negedge clk);
    e = '0;
    if (m_cnt[inst] == sz[inst]) begin
      e.wrap       = 1'b1;
      m_used[inst] = '0;
      m_cnt[inst]  = 0;
    end
    cand = shuf ? (int'(m_lfsr[inst]) & (sz[inst] - 1)) : m_seq[inst];
    k = 0;
    while (m_used[inst][cand]) begin
      cand = (cand + 1) % sz[inst];
      k++;
    end
    m_used[inst][cand] = 1'b1;
    m_seq[inst] = (cand + 1) % sz[inst];
    m_cnt[inst]++;
    e.idx  = 5'(cand);
    e.nums = TABLE[cand];
    e.cnt  = 6'(m_cnt[inst]);
    e.lat  = 6'(2 + k);
    exp_q.push_back(e);

    if (inst == 0) begin bus_a.deal_req = 1'b1; bus_a.shuffle_en = shuf; end
    else           begin bus_b.deal_req = 1'b1; bus_b.shuffle_en = shuf; end
    obs = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      bus_a.deal_req = 1'b0;
      bus_b.deal_req = 1'b0;
      if (inst == 0) begin
        v = bus_a.deal_valid;
        w = bus_a.deck_wrap;
        if (v) begin
          obs.idx  = bus_a.set_idx;
          obs.nums = {bus_a.num1, bus_a.num2, bus_a.num3, bus_a.num4};
          obs.cnt  = bus_a.dealt_count;
        end
      end else begin
        v = bus_b.deal_valid;
        w = bus_b.deck_wrap;
        if (v) begin
          obs.idx  = {1'b0, bus_b.set_idx};
          obs.nums = {bus_b.num1, bus_b.num2, bus_b.num3, bus_b.num4};
          obs.cnt  = {1'b0, bus_b.dealt_count};
        end
      end
      if (w) obs.wrap = 1'b1;
      if (v) begin
        obs.lat = 6'(n);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus_a.busy, bus_a.deal_valid, bus_a.deck_wrap, bus_a.set_idx, bus_a.dealt_count,
         bus_a.num1, bus_a.num2, bus_a.num3, bus_a.num4} !== '0)
      $display("[TB] FAIL reset_a got busy=%b valid=%b wrap=%b idx=%0d cnt=%0d nums=%h%h%h%h expected all zero",
               bus_a.busy, bus_a.deal_valid, bus_a.deck_wrap, bus_a.set_idx, bus_a.dealt_count,
               bus_a.num1, bus_a.num2, bus_a.num3, bus_a.num4);
    else n_pass++;
    n_checks++;
    if ({bus_b.busy, bus_b.deal_valid, bus_b.set_idx, bus_b.dealt_count} !== '0)
      $display("[TB] FAIL reset_b got busy=%b valid=%b idx=%0d cnt=%0d expected all zero",
               bus_b.busy, bus_b.deal_valid, bus_b.set_idx, bus_b.dealt_count);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_sequential();
    rec_t obs;
    rec_t e;
    for (int i = 0; i < 3; i++) begin
      deal(0, 1'b0, obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e || obs.idx !== 5'(i) || obs.lat !== 6'd2)
        $display("[TB] FAIL seq_deal%0d got %h expected %h", i, obs, e);
      else n_pass++;
    end
  endtask

  task automatic test_deck_wrap();
    rec_t obs;
    rec_t e;
    for (int i = 3; i < 33; i++) begin
      deal(0, 1'b0, obs);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e)
        $display("[TB] FAIL wrap_deal%0d got %h expected %h", i, obs, e);
      else n_pass++;
    end
    n_checks++;
    if (obs.wrap !== 1'b1 || obs.idx !== 5'd0 || obs.nums !== 16'h248B || obs.cnt !== 6'd1)
      $display("[TB] FAIL wrap_restart got wrap=%b idx=%0d nums=%h cnt=%0d expected 1 0 248b 1",
               obs.wrap, obs.idx, obs.nums, obs.cnt);
    else n_pass++;
  endtask

  task automatic test_shuffle();
    rec_t        obs;
    rec_t        e;
    logic [31:0] seen;
    logic        any_wrap;
    do_reset();
    seen     = '0;
    any_wrap = 1'b0;
    for (int i = 0; i < 32; i++) begin
      deal(0, 1'b1, obs);
      e = exp_q.pop_front();
      seen[obs.idx] = 1'b1;
      any_wrap = any_wrap | obs.wrap;
      n_checks++;
      if (obs !== e)
        $display("[TB] FAIL shuf_deal%0d got %h expected %h", i, obs, e);
      else n_pass++;
    end
    n_checks++;
    if (seen !== 32'hFFFF_FFFF || any_wrap !== 1'b0)
      $display("[TB] FAIL shuf_cover got seen=%h wrap=%b expected ffffffff 0", seen, any_wrap);
    else n_pass++;
  endtask

  task automatic test_last_free();
    rec_t obs;
    rec_t e;
    do_reset();
    for (int i = 0; i < 31; i++) begin
      deal(0, 1'b0, obs);
      void'(exp_q.pop_front());
    end
    deal(0, 1'b1, obs);
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e || obs.idx !== 5'd31 || obs.nums !== 16'h1699 || obs.cnt !== 6'd32)
      $display("[TB] FAIL last_free got %h expected %h", obs, e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [4:0] last_idx;
    do_reset();
    pulses   = 0;
    last_idx = '0;
    @(negedge clk);
    bus_a.deal_req   = 1'b1;
    bus_a.shuffle_en = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus_a.deal_valid) begin
        pulses++;
        last_idx = bus_a.set_idx;
      end
    end
    bus_a.deal_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pulses != 3 || last_idx !== 5'd2 || bus_a.dealt_count !== 6'd3 || bus_a.busy !== 1'b0)
      $display("[TB] FAIL back_to_back got pulses=%0d idx=%0d cnt=%0d busy=%b expected 3 2 3 0",
               pulses, last_idx, bus_a.dealt_count, bus_a.busy);
    else n_pass++;
  endtask

  task automatic test_reset_in_scan();
    rec_t obs;
    rec_t e;
    int   pulses;
    do_reset();
    deal(0, 1'b0, obs);
    e = exp_q.pop_front();
    n_checks++;
    if (obs !== e)
      $display("[TB] FAIL pre_abort_deal got %h expected %h", obs, e);
    else n_pass++;
    @(negedge clk);
    bus_a.deal_req = 1'b1;
    @(negedge clk);
    bus_a.deal_req = 1'b0;
    n_checks++;
    if (bus_a.busy !== 1'b1)
      $display("[TB] FAIL abort_busy got %b expected 1", bus_a.busy);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus_a.busy, bus_a.dealt_count, bus_a.num1, bus_a.num2, bus_a.num3, bus_a.num4} !== '0)
      $display("[TB] FAIL abort_clear got busy=%b cnt=%0d nums=%h%h%h%h expected all zero",
               bus_a.busy, bus_a.dealt_count, bus_a.num1, bus_a.num2, bus_a.num3, bus_a.num4);
    else n_pass++;
    pulses = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (bus_a.deal_valid) pulses++;
    end
    n_checks++;
    if (pulses != 0 || bus_a.dealt_count !== 6'd0)
      $display("[TB] FAIL abort_no_deal got pulses=%0d cnt=%0d expected 0 0", pulses, bus_a.dealt_count);
    else n_pass++;
  endtask

  task automatic test_small_deck();
    rec_t        obs;
    rec_t        e;
    logic [31:0] seen;
    do_reset();
    seen = '0;
    for (int i = 0; i < 17; i++) begin
      deal(1, 1'b1, obs);
      e = exp_q.pop_front();
      if (i < 16) seen[obs.idx] = 1'b1;
      n_checks++;
      if (obs !== e || obs.idx > 5'd15)
        $display("[TB] FAIL small_deal%0d got %h expected %h", i, obs, e);
      else n_pass++;
    end
    n_checks++;
    if (seen !== 32'h0000_FFFF || obs.wrap !== 1'b1 || obs.cnt !== 6'd1)
      $display("[TB] FAIL small_cover got seen=%h wrap=%b cnt=%0d expected 0000ffff 1 1",
               seen, obs.wrap, obs.cnt);
    else n_pass++;
  endtask

  initial begin
    bus_a.deal_req   = 1'b0;
    bus_a.shuffle_en = 1'b0;
    bus_b.deal_req   = 1'b0;
    bus_b.shuffle_en = 1'b0;
    test_reset();
    test_sequential();
    test_deck_wrap();
    test_shuffle();
    test_last_free();
    test_back_to_back();
    test_reset_in_scan();
    test_small_deck();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/puzzle_dealer.md
Name: puzzle_dealer

Overview:
Sequential successor to the combinational puzzle-set lookup. Holds a fixed table of up to 32 solvable four-number 24-game sets and deals one set per request, in sequential or shuffled order. Within a deck no set repeats; once every set has been dealt, the deck reshuffles automatically. It sits between the game-control FSM (request side) and the display/number-entry logic (num outputs).

Parameters:
SET_COUNT, 32, table depth in use; legal values 16 or 32 only.
IDX_W, 5, index width; must equal log2(SET_COUNT).
NUM_W, 4, width of each dealt number.
LFSR_SEED, 5'h15, non-zero reset value of the shuffle LFSR (low IDX_W bits used).

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
deal_req  in  1  request a new set; sampled only in IDLE
shuffle_en  in  1  1 = random start point, 0 = sequential; sampled with deal_req
num1  out  NUM_W  first number of dealt set (registered)
num2  out  NUM_W  second number
num3  out  NUM_W  third number
num4  out  NUM_W  fourth number
set_idx  out  IDX_W  table index of dealt set
deal_valid  out  1  one-cycle pulse: new set on num1..num4/set_idx
busy  out  1  high whenever state != IDLE
deck_wrap  out  1  one-cycle pulse: used-mask cleared, new deck started
dealt_count  out  IDX_W+1  sets dealt in current deck, 0..SET_COUNT

Behaviour:
- Table {num1,num2,num3,num4} by index, numbers 1..13:
  - 0-7: {2,4,8,11} {2,6,12,13} {3,5,7,13} {3,6,6,11} {1,3,7,12} {7,8,9,10} {2,6,11,12} {3,4,8,13}
  - 8-15: {3,6,10,10} {4,4,9,12} {4,6,7,9} {5,6,11,13} {8,8,11,12} {11,12,12,13} {1,3,4,6} {7,8,10,13}
  - 16-23: {1,2,3,4} {1,1,3,8} {2,2,2,3} {4,4,4,6} {1,5,5,5} {3,3,8,8} {6,6,6,6} {2,3,4,12}
  - 24-31: {1,6,6,8} {3,4,5,6} {1,2,7,7} {2,5,9,10} {4,4,10,10} {1,4,5,6} {2,3,5,12} {1,6,9,9}
  - With SET_COUNT=16, entries 16-31 are unreachable.
- Reset (async): state IDLE; used mask 0; seq_ptr 0; lfsr=LFSR_SEED; num1..num4=0; set_idx=0; deal_valid=0; deck_wrap=0; dealt_count=0. Reset wins over a simultaneous deal_req. Reset during SCAN aborts the scan: no deal_valid, no mask update.
- LFSR: Fibonacci, advances every clock edge out of reset. Polynomial x^5+x^3+1 for IDX_W=5, x^4+x^3+1 for IDX_W=4. Never reaches 0.
- FSM states: IDLE, SCAN.
- IDLE, deal_req=1 at edge t:
  - cand <= shuffle_en ? lfsr : seq_ptr.
  - If dealt_count==SET_COUNT: mask <= 0, dealt_count <= 0, deck_wrap=1 in the cycle after edge t.
  - -> SCAN.
- deal_req=0, or deal_req while busy: ignored, no queuing.
- SCAN, each edge:
  - used[cand]=1: cand <= (cand+1) mod SET_COUNT; stay in SCAN.
  - used[cand]=0: load num1..num4/set_idx from table[cand]; used[cand] <= 1; seq_ptr <= (cand+1) mod SET_COUNT; dealt_count <= dealt_count+1; deal_valid=1 for exactly one cycle; -> IDLE.
- Latency: deal_valid is high in the cycle after edge t+1+k, where k = number of used entries skipped. Minimum 2 edges; k ≤ SET_COUNT-1. SCAN always terminates because the deck is never full on entry to SCAN.
- Outputs hold the last dealt set until the next deal.
- A new deal_req is accepted in the same cycle deal_valid is high, since state is already IDLE.

Test Plan:
- Reset, then shuffle_en=0 with three requests -> set_idx 0,1,2; nums {2,4,8,11}, {2,6,12,13}, {3,5,7,13}; deal_valid exactly 2 edges after each request; dealt_count 1,2,3.
- 32 sequential deals, then a 33rd request -> deck_wrap pulses once; deal returns set_idx 0 {2,4,8,11}; dealt_count=1.
- Reset, then 32 shuffled deals -> all 32 set_idx values distinct; no deck_wrap; each latency = 2 + skips, matching the reference model with LFSR_SEED=5'h15.
- Sequential deals of 0..30, then one shuffled request -> set_idx 31 {1,6,9,9} regardless of LFSR value; dealt_count=32.
- deal_req held high while busy -> exactly one deal per IDLE acceptance. Assert rst during SCAN -> deal_valid never pulses; nums=0, dealt_count=0, busy=0 immediately.
- SET_COUNT=16, IDX_W=4 instance -> 16 shuffled deals cover indices 0..15 once each, set_idx never >15; 17th request -> deck_wrap and dealt_count=1.
